// File: rtl/matmul_addr_gen_if.sv
// Handshake and address bundle between the matmul loop sequencer and the MAC datapath.
// The slave modport is the sequencer side; the master modport is the controller/datapath side.
interface matmul_addr_gen_if #(
   parameter int N    = 8,
   parameter int LOGN = $clog2(N),
   parameter int AW   = 2 * LOGN
);
   logic          start;
   logic          stall;
   logic          busy;
   logic          done;
   logic          mac_valid;
   logic          mac_clear;
   logic          c_write;
   logic [AW-1:0] addr_A;
   logic [AW-1:0] addr_B;
   logic [AW-1:0] addr_C;

   modport master (
      output start, stall,
      input  busy, done, mac_valid, mac_clear, c_write, addr_A, addr_B, addr_C
   );

   modport slave (
      input  start, stall,
      output busy, done, mac_valid, mac_clear, c_write, addr_A, addr_B, addr_C
   );
endinterface

// File: rtl/matmul_addr_gen.sv
// Loop sequencer for an NxN matrix multiply: walks i/j/k and issues one MAC beat per
// unstalled cycle with row-major A/B/C addresses, accumulate-clear and write-back strobes.
module matmul_addr_gen #(
   parameter int N    = 8,
   parameter int LOGN = $clog2(N),
   parameter int AW   = 2 * LOGN
) (
   input  logic              clk,
   input  logic              rst_n,
   matmul_addr_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [LOGN-1:0] IDX_MAX = LOGN'(N - 1);

   state_e          state_q, state_d;
   logic [LOGN-1:0] i_q, i_d;
   logic [LOGN-1:0] j_q, j_d;
   logic [LOGN-1:0] k_q, k_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   // Each loop wraps explicitly at N-1 and carries into the next-outer loop.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         RUN: begin
            if (!bus.stall) begin
               if (k_q == IDX_MAX) begin
                  k_d = '0;
                  if (j_q == IDX_MAX) begin
                     j_d = '0;
                     if (i_q == IDX_MAX) begin
                        i_d     = '0;
                        state_d = DONE;
                     end else begin
                        i_d = i_q + 1'b1;
                     end
                  end else begin
                     j_d = j_q + 1'b1;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Addresses track the counters for the whole of RUN so they stay put during a stall.
   always_comb begin
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.mac_valid = 1'b0;
      bus.mac_clear = 1'b0;
      bus.c_write   = 1'b0;
      bus.addr_A    = '0;
      bus.addr_B    = '0;
      bus.addr_C    = '0;
      if (state_q == RUN) begin
         bus.busy      = 1'b1;
         bus.mac_valid = !bus.stall;
         bus.mac_clear = !bus.stall && (k_q == '0);
         bus.c_write   = !bus.stall && (k_q == IDX_MAX);
         bus.addr_A    = {i_q, k_q};
         bus.addr_B    = {k_q, j_q};
         bus.addr_C    = {i_q, j_q};
      end else if (state_q == DONE) begin
         bus.done = 1'b1;
      end
   end

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Scoreboard bench for matmul_addr_gen: drives N=8 and N=4 instances with clean, stalled,
// re-started and aborted runs and checks every cycle against an arithmetic loop-nest model.
module tb_matmul_addr_gen;

   typedef struct packed {
      logic [5:0] a;
      logic [5:0] b;
      logic [5:0] c;
      logic       clr;
      logic       wr;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] startV;
   logic [1:0] stallV;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int beatCnt[2];
   int cwCnt[2];

   beat_t expQ[2][$];
   int    doneQ[2][$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   matmul_addr_gen_if #(.N(8)) if8 ();
   matmul_addr_gen_if #(.N(4)) if4 ();

   assign if8.start = startV[0];
   assign if8.stall = stallV[0];
   assign if4.start = startV[1];
   assign if4.stall = stallV[1];

   matmul_addr_gen #(.N(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   matmul_addr_gen #(.N(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if4)
   );

   function automatic void compare(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Expected per-cycle behaviour: busy while model beats remain, done on the predicted cycle,
   // beats popped in loop-nest order, addresses of the pending beat held while stalled.
   task automatic checkOutput(input int sel, input logic valid, input logic clr, input logic wr,
                              input logic busy, input logic done, input logic stl,
                              input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      beat_t ex;
      bit    expBusy;
      bit    expDone;
      expBusy = expQ[sel].size() != 0;
      expDone = (doneQ[sel].size() != 0) && (doneQ[sel][0] == cyc);
      compare($sformatf("busy%0d", sel), 64'(busy), 64'(expBusy));
      compare($sformatf("mac_valid%0d", sel), 64'(valid), 64'(expBusy && !stl));
      compare($sformatf("done%0d", sel), 64'(done), 64'(expDone));
      if (expDone) void'(doneQ[sel].pop_front());
      if (valid) begin
         beatCnt[sel]++;
         if (wr) cwCnt[sel]++;
         if (expQ[sel].size() == 0) begin
            compare($sformatf("extra_beat%0d", sel), 64'(1), 64'(0));
         end else begin
            ex = expQ[sel].pop_front();
            compare($sformatf("beat%0d", sel), 64'({a, b, c, clr, wr}), 64'(ex));
         end
      end else if (busy && expBusy) begin
         ex = expQ[sel][0];
         compare($sformatf("stall_hold%0d", sel), 64'({a, b, c, clr, wr}),
                 64'({ex.a, ex.b, ex.c, 2'b00}));
      end else if (!busy) begin
         compare($sformatf("idle_outputs%0d", sel), 64'({a, b, c, clr, wr}), 64'(0));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checkOutput(0, if8.mac_valid, if8.mac_clear, if8.c_write, if8.busy, if8.done, stallV[0],
                     6'(if8.addr_A), 6'(if8.addr_B), 6'(if8.addr_C));
         checkOutput(1, if4.mac_valid, if4.mac_clear, if4.c_write, if4.busy, if4.done, stallV[1],
                     6'(if4.addr_A), 6'(if4.addr_B), 6'(if4.addr_C));
      end
   end

   // stallMode: 0 none, 1 random, 2 four cycles on the third beat.
   // restartAt / abortAt are beat indices (-1 disables); startAtDone re-pulses start with done.
   task automatic applyStimulus(input int sel, input int n, input int stallMode,
                                input int restartAt, input bit startAtDone, input int abortAt);
      int  beats    = 0;
      int  stalls   = 0;
      int  startCyc;
      bit  s;
      beatCnt[sel] = 0;
      cwCnt[sel]   = 0;
      startV[sel]  = 1'b1;
      startCyc     = cyc;
      @(posedge clk);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            for (int k = 0; k < n; k++)
               expQ[sel].push_back(beat_t'{a: 6'(i * n + k), b: 6'(k * n + j), c: 6'(i * n + j),
                                           clr: (k == 0), wr: (k == n - 1)});
      #1 startV[sel] = 1'b0;
      while (beats < n * n * n) begin
         if (beats == abortAt) begin
            #2 rst_n = 1'b0;
            #1;
            compare("async_reset", 64'({if8.busy, if8.done, if8.mac_valid, if8.mac_clear,
                                        if8.c_write, if8.addr_A, if8.addr_B, if8.addr_C}), 64'(0));
            expQ[0].delete();
            expQ[1].delete();
            doneQ[0].delete();
            doneQ[1].delete();
            stallV = 2'b00;
            startV = 2'b00;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
         case (stallMode)
            1:       s = ($urandom_range(0, 3) == 0);
            2:       s = (beats == 2) && (stalls < 4);
            default: s = 1'b0;
         endcase
         stallV[sel] = s;
         startV[sel] = (beats == restartAt);
         if (s) stalls++;
         else   beats++;
         @(posedge clk);
         #1;
      end
      stallV[sel] = 1'b0;
      doneQ[sel].push_back(startCyc + 1 + n * n * n + stalls);
      startV[sel] = startAtDone;
      @(posedge clk);
      #1 startV[sel] = 1'b0;
      compare($sformatf("beat_count%0d", sel), 64'(beatCnt[sel]), 64'(n * n * n));
      compare($sformatf("cwrite_count%0d", sel), 64'(cwCnt[sel]), 64'(n * n));
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      startV = 2'b11;
      stallV = 2'b00;
      #12;
      compare("reset8", 64'({if8.busy, if8.done, if8.mac_valid, if8.mac_clear, if8.c_write,
                             if8.addr_A, if8.addr_B, if8.addr_C}), 64'(0));
      compare("reset4", 64'({if4.busy, if4.done, if4.mac_valid, if4.mac_clear, if4.c_write,
                             if4.addr_A, if4.addr_B, if4.addr_C}), 64'(0));
      @(posedge clk);
      #1;
      startV = 2'b00;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(0, 8, 0, -1, 1'b0, -1);
      applyStimulus(0, 8, 2, -1, 1'b0, -1);
      applyStimulus(0, 8, 1, 50, 1'b1, -1);
      applyStimulus(0, 8, 0, -1, 1'b0, 100);
      applyStimulus(0, 8, 0, -1, 1'b0, -1);
      applyStimulus(1, 4, 0, -1, 1'b0, -1);
      applyStimulus(1, 4, 1, 10, 1'b1, -1);
      compare("queues_drained", 64'(expQ[0].size() + expQ[1].size() + doneQ[0].size()
                                    + doneQ[1].size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
